// File: rtl/alu_pwm_pkg.sv
// Shared types and constants for the ALU-fed PWM stage.
// Flag order matches the ALU flag bus {N,Z,C,V}.
package alu_pwm_pkg;

    localparam int DEFAULT_WIDTH    = 4;
    localparam int DEFAULT_PRESCALE = 1024;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    function automatic alu_flags_t to_flags(input logic [3:0] raw);
        return alu_flags_t'(raw);
    endfunction

endpackage

// File: rtl/alu_pwm_stage_prescaler.sv
// Clock prescaler: emits a one-cycle step every PRESCALE enabled cycles.
// Shared by the PWM blocks; PRESCALE=1 yields a step on every enabled cycle.
module pwm_prescaler #(
    parameter int PRESCALE = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic step
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] pre_cnt;

    assign step = en && (pre_cnt == LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= step ? '0 : pre_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/alu_pwm_stage.sv
// PWM stage fed by the 4-bit ALU: Result becomes the duty, flags are latched.
// Optional: define ALU_PWM_OVF_GUARD_EN to reject loads whose V flag is set.
module alu_pwm_stage
    import alu_pwm_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] result_in,
    input  logic [3:0]       flags_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic [WIDTH-1:0] duty_q,
    output logic [3:0]       flags_q,
    output logic             period_tick,
    output logic             pwm_out,
    output logic             ovf_err
);

    // Period is 2^WIDTH-1 steps so a full-scale duty means 100% high.
    localparam logic [WIDTH-1:0] STEP_MAX = {{(WIDTH-1){1'b1}}, 1'b0};

    logic             step;
    logic             wrap;
    logic             accept;
    logic             take;
    logic             pending;
    logic [WIDTH-1:0] step_cnt;
    logic [WIDTH-1:0] shadow;
    alu_flags_t       flags_r;

    pwm_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .step (step)
    );

    assign wrap       = step && (step_cnt == STEP_MAX);
    assign load_ready = ~pending;
    assign accept     = load_valid & load_ready;
    assign flags_q    = flags_r;

`ifdef ALU_PWM_OVF_GUARD_EN
    // Overflowed results are handshaken away so upstream never stalls on them.
    assign take = accept & ~flags_in[FLAG_V];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_err <= 1'b0;
        end else if (accept && flags_in[FLAG_V]) begin
            ovf_err <= 1'b1;
        end
    end
`else
    assign take    = accept;
    assign ovf_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt    <= '0;
            period_tick <= 1'b0;
            pwm_out     <= 1'b0;
        end else begin
            period_tick <= wrap;
            pwm_out     <= en && (step_cnt < duty_q);
            if (step) begin
                step_cnt <= wrap ? '0 : step_cnt + WIDTH'(1);
            end
        end
    end

    // Apply and accept are exclusive: apply needs pending=1, accept needs pending=0,
    // so a load taken on a wrap edge waits for the following wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow  <= '0;
            duty_q  <= '0;
            flags_r <= '0;
            pending <= 1'b0;
        end else begin
            if (wrap && pending) begin
                duty_q  <= shadow;
                pending <= 1'b0;
            end
            if (take) begin
                shadow  <= result_in;
                flags_r <= to_flags(flags_in);
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_pwm_stage.sv
// Directed self-checking bench for alu_pwm_stage with WIDTH=4, PRESCALE=1.
// Build with ALU_PWM_OVF_GUARD_EN defined to exercise the overflow guard.
module tb_alu_pwm_stage;
    import alu_pwm_pkg::*;

    logic       clk        = 1'b0;
    logic       rst        = 1'b0;
    logic       en         = 1'b0;
    logic [3:0] result_in  = '0;
    logic [3:0] flags_in   = '0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [3:0] duty_q;
    logic [3:0] flags_q;
    logic       period_tick;
    logic       pwm_out;
    logic       ovf_err;

    int total = 0;
    int bad   = 0;

    alu_pwm_stage #(
        .WIDTH    (4),
        .PRESCALE (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .result_in   (result_in),
        .flags_in    (flags_in),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .duty_q      (duty_q),
        .flags_q     (flags_q),
        .period_tick (period_tick),
        .pwm_out     (pwm_out),
        .ovf_err     (ovf_err)
    );

    always #5 clk = ~clk;

    // Expected reset image: {pwm_out, duty_q, flags_q, load_ready, period_tick, ovf_err}
    localparam logic [11:0] RESET_IMAGE = {1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0};

    task automatic do_load(input logic [3:0] r, input logic [3:0] f);
        int n = 0;
        @(negedge clk);
        result_in  = r;
        flags_in   = f;
        load_valid = 1'b1;
        while (!load_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 64) begin
            bad++;
            $display("FAIL load_timeout: load_ready=%b after %0d cycles, required 1", load_ready, n);
        end
        @(posedge clk);
        #1 load_valid = 1'b0;
    endtask

    // Returns at the negedge just after a wrap that applied the pending duty.
    task automatic wait_apply();
        int n = 0;
        @(negedge clk);
        while (!(period_tick && load_ready) && n < 64) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 64) begin
            bad++;
            $display("FAIL apply_timeout: no applying wrap in %0d cycles", n);
        end
    endtask

    // Called at the negedge after a wrap; walks the following 15-step period.
    task automatic check_period(input int d);
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            total++;
            if (pwm_out !== (k <= d)) begin
                bad++;
                $display("FAIL pwm_d%0d_k%0d: pwm_out=%b required %b", d, k, pwm_out, (k <= d));
            end
            total++;
            if (period_tick !== (k == 15)) begin
                bad++;
                $display("FAIL tick_d%0d_k%0d: period_tick=%b required %b", d, k, period_tick, (k == 15));
            end
            if (k < 15) begin
                total++;
                if (duty_q !== 4'(d)) begin
                    bad++;
                    $display("FAIL duty_hold_d%0d_k%0d: duty_q=%0d required %0d", d, k, duty_q, d);
                end
            end
        end
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        total++;
        if ({pwm_out, duty_q, flags_q, load_ready, period_tick, ovf_err} !== RESET_IMAGE) begin
            bad++;
            $display("FAIL reset_async: outputs=%b required %b",
                     {pwm_out, duty_q, flags_q, load_ready, period_tick, ovf_err}, RESET_IMAGE);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
    endtask

    task automatic test_duty5();
        do_load(4'd5, 4'b0000);
        @(negedge clk);
        total++;
        if (load_ready !== 1'b0) begin
            bad++;
            $display("FAIL duty5_ready_low: load_ready=%b required 0", load_ready);
        end
        wait_apply();
        total++;
        if (duty_q !== 4'd5) begin
            bad++;
            $display("FAIL duty5_applied: duty_q=%0d required 5", duty_q);
        end
        check_period(5);
        check_period(5);
    endtask

    task automatic test_extremes();
        do_load(4'd15, 4'b0110);
        @(negedge clk);
        total++;
        if (flags_q !== 4'b0110) begin
            bad++;
            $display("FAIL flags_immediate: flags_q=%b required 0110", flags_q);
        end
        wait_apply();
        check_period(15);
        do_load(4'd0, 4'b0100);
        wait_apply();
        check_period(0);
    endtask

    task automatic test_back_to_back();
        int n = 0;
        result_in  = 4'd3;
        flags_in   = 4'b1000;
        load_valid = 1'b1;
        @(negedge clk);
        result_in = 4'd9;
        total++;
        if (load_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_ready_low: load_ready=%b required 0", load_ready);
        end
        while (!(period_tick && load_ready) && n < 64) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 64 || duty_q !== 4'd3 || flags_q !== 4'b1000) begin
            bad++;
            $display("FAIL b2b_first: duty_q=%0d flags_q=%b after %0d cycles, required 3/1000",
                     duty_q, flags_q, n);
        end
        @(posedge clk);
        #1 load_valid = 1'b0;
        check_period(3);
        total++;
        if (duty_q !== 4'd9 || load_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second: duty_q=%0d load_ready=%b required 9/1", duty_q, load_ready);
        end
        check_period(9);
    endtask

    task automatic test_enable_gating();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if (pwm_out !== 1'b1) begin
                bad++;
                $display("FAIL gate_pre_k%0d: pwm_out=%b required 1", k, pwm_out);
            end
        end
        en = 1'b0;
        for (int k = 5; k <= 11; k++) begin
            @(negedge clk);
            total++;
            if (pwm_out !== 1'b0 || period_tick !== 1'b0 || dut.step_cnt !== 4'd4) begin
                bad++;
                $display("FAIL gate_pause_k%0d: pwm=%b tick=%b step_cnt=%0d required 0/0/4",
                         k, pwm_out, period_tick, dut.step_cnt);
            end
        end
        en = 1'b1;
        for (int k = 12; k <= 22; k++) begin
            @(negedge clk);
            total++;
            if (pwm_out !== ((k - 7) <= 9) || period_tick !== (k == 22)) begin
                bad++;
                $display("FAIL gate_resume_k%0d: pwm=%b tick=%b required %b/%b",
                         k, pwm_out, period_tick, ((k - 7) <= 9), (k == 22));
            end
        end
    endtask

    task automatic test_overflow();
        do_load(4'd7, 4'b0001);
`ifdef ALU_PWM_OVF_GUARD_EN
        @(negedge clk);
        total++;
        if (load_ready !== 1'b1 || ovf_err !== 1'b1) begin
            bad++;
            $display("FAIL ovf_reject: load_ready=%b ovf_err=%b required 1/1", load_ready, ovf_err);
        end
        repeat (20) @(negedge clk);
        total++;
        if (duty_q !== 4'd9 || flags_q !== 4'b1000 || ovf_err !== 1'b1) begin
            bad++;
            $display("FAIL ovf_sticky: duty_q=%0d flags_q=%b ovf_err=%b required 9/1000/1",
                     duty_q, flags_q, ovf_err);
        end
`else
        @(negedge clk);
        total++;
        if (load_ready !== 1'b0 || flags_q !== 4'b0001 || ovf_err !== 1'b0) begin
            bad++;
            $display("FAIL ovf_accept: ready=%b flags_q=%b ovf_err=%b required 0/0001/0",
                     load_ready, flags_q, ovf_err);
        end
        wait_apply();
        total++;
        if (duty_q !== 4'd7 || ovf_err !== 1'b0) begin
            bad++;
            $display("FAIL ovf_applied: duty_q=%0d ovf_err=%b required 7/0", duty_q, ovf_err);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_load(4'd12, 4'b1110);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({pwm_out, duty_q, flags_q, load_ready, period_tick, ovf_err} !== RESET_IMAGE) begin
            bad++;
            $display("FAIL reset_mid: outputs=%b required %b",
                     {pwm_out, duty_q, flags_q, load_ready, period_tick, ovf_err}, RESET_IMAGE);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_duty5();
        test_extremes();
        test_back_to_back();
        test_enable_gating();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
